// File: rtl/struct_record_unpacker_pkg.sv
// Shared widths and FSM state type for the struct record unpacker.
package struct_record_pkg;

  localparam int unsigned ELEM_W   = 8;
  localparam int unsigned FILLER_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT_A = 2'd1,
    EMIT_B = 2'd2
  } unpack_state_t;

endpackage

// File: rtl/struct_record_unpacker_if.sv
// Record-in / byte-out handshake bundle for the struct record unpacker.
// Carries out_parity only when STRUCT_UNPACK_PARITY_EN is defined.
interface struct_record_unpacker_if
  import struct_record_pkg::*;
#(
  parameter int unsigned NUM_ELEMS = 6,
  localparam int unsigned REC_W    = NUM_ELEMS * ELEM_W + FILLER_W,
  localparam int unsigned IDX_W    = $clog2(NUM_ELEMS + 2)
) ();

  logic              in_valid;
  logic              in_ready;
  logic [REC_W-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [ELEM_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;
`ifdef STRUCT_UNPACK_PARITY_EN
  logic              out_parity;
`endif

  // Record source / byte sink side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
`ifdef STRUCT_UNPACK_PARITY_EN
    , input out_parity
`endif
  );

  // Unpacker side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
`ifdef STRUCT_UNPACK_PARITY_EN
    , output out_parity
`endif
  );

endinterface

// File: rtl/struct_record_unpacker_elem_mux.sv
// Combinational byte select from a packed record by beat index and order.
module struct_elem_mux
  import struct_record_pkg::*;
#(
  parameter int unsigned NUM_ELEMS = 6,
  parameter int unsigned ASCENDING = 0,
  localparam int unsigned REC_W    = NUM_ELEMS * ELEM_W + FILLER_W,
  localparam int unsigned IDX_W    = $clog2(NUM_ELEMS + 2),
  localparam int unsigned SEL_W    = $clog2(NUM_ELEMS)
) (
  input  logic [REC_W-1:0]  rec,
  input  logic [IDX_W-1:0]  idx,
  output logic [ELEM_W-1:0] data_c
);

  typedef struct packed {
    logic [NUM_ELEMS-1:0][ELEM_W-1:0] a;
    logic [FILLER_W-1:0]              b;
  } record_t;

  record_t          r;
  logic [SEL_W-1:0] elem;

  assign r = record_t'(rec);

  // Beats 0..NUM_ELEMS-1 walk field a; the last two beats are b high then low
  always_comb begin
    data_c = '0;
    elem   = '0;
    if (idx < IDX_W'(NUM_ELEMS)) begin
      if (ASCENDING != 0) elem = SEL_W'(idx);
      else                elem = SEL_W'(IDX_W'(NUM_ELEMS - 1) - idx);
      data_c = r.a[elem];
    end else if (idx == IDX_W'(NUM_ELEMS)) begin
      data_c = r.b[FILLER_W-1 -: ELEM_W];
    end else begin
      data_c = r.b[ELEM_W-1:0];
    end
  end

endmodule

// File: rtl/struct_record_unpacker.sv
// Captures a whole packed record and streams it out one byte per beat.
// Optional out_parity output enabled by STRUCT_UNPACK_PARITY_EN.
module struct_record_unpacker
  import struct_record_pkg::*;
#(
  parameter int unsigned NUM_ELEMS = 6,
  parameter int unsigned ASCENDING = 0,
  localparam int unsigned REC_W    = NUM_ELEMS * ELEM_W + FILLER_W,
  localparam int unsigned IDX_W    = $clog2(NUM_ELEMS + 2)
) (
  input logic                    clk,
  input logic                    rst_n,
  struct_record_unpacker_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_ELEMS + 1);
  localparam logic [IDX_W-1:0] FIRST_B   = IDX_W'(NUM_ELEMS);

  unpack_state_t     state;
  logic [REC_W-1:0]  rec_q;
  logic [REC_W-1:0]  mux_src;
  logic [IDX_W-1:0]  mux_idx;
  logic [IDX_W-1:0]  next_idx;
  logic [ELEM_W-1:0] mux_byte_c;

  assign next_idx = IDX_W'(bus.out_idx + IDX_W'(1));

  // In IDLE the first beat is taken straight from in_data so it is ready one cycle after capture
  always_comb begin
    mux_src = rec_q;
    mux_idx = next_idx;
    if (state == IDLE) begin
      mux_src = bus.in_data;
      mux_idx = '0;
    end
  end

  struct_elem_mux #(
    .NUM_ELEMS (NUM_ELEMS),
    .ASCENDING (ASCENDING)
  ) u_elem_mux (
    .rec    (mux_src),
    .idx    (mux_idx),
    .data_c (mux_byte_c)
  );

  // Capture / emit FSM with all handshake and beat outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rec_q         <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_idx   <= '0;
      bus.out_last  <= 1'b0;
`ifdef STRUCT_UNPACK_PARITY_EN
      bus.out_parity <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state         <= EMIT_A;
            rec_q         <= bus.in_data;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b1;
            bus.out_data  <= mux_byte_c;
            bus.out_idx   <= '0;
            bus.out_last  <= 1'b0;
`ifdef STRUCT_UNPACK_PARITY_EN
            bus.out_parity <= ^mux_byte_c;
`endif
          end
        end
        EMIT_A, EMIT_B: begin
          if (bus.out_ready) begin
            if (bus.out_idx == LAST_IDX) begin
              state         <= IDLE;
              bus.in_ready  <= 1'b1;
              bus.out_valid <= 1'b0;
              bus.out_idx   <= '0;
              bus.out_last  <= 1'b0;
            end else begin
              state        <= (next_idx >= FIRST_B) ? EMIT_B : EMIT_A;
              bus.out_data <= mux_byte_c;
              bus.out_idx  <= next_idx;
              bus.out_last <= (next_idx == LAST_IDX);
`ifdef STRUCT_UNPACK_PARITY_EN
              bus.out_parity <= ^mux_byte_c;
`endif
            end
          end
        end
        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_struct_record_unpacker.sv
// Bench for struct_record_unpacker: descending and ascending instances run side by side.
module tb_struct_record_unpacker;
  import struct_record_pkg::*;

  localparam int unsigned N     = 6;
  localparam int unsigned REC_W = N * 8 + 16;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  struct_record_unpacker_if #(.NUM_ELEMS(N)) bus0 ();
  struct_record_unpacker_if #(.NUM_ELEMS(N)) bus1 ();

  struct_record_unpacker #(.NUM_ELEMS(N), .ASCENDING(0)) dut0 (
    .clk (clk), .rst_n (rst_n), .bus (bus0.slave)
  );
  struct_record_unpacker #(.NUM_ELEMS(N), .ASCENDING(1)) dut1 (
    .clk (clk), .rst_n (rst_n), .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: byte k of the stream, straight from the record layout
  function automatic logic [7:0] model_byte(input logic [REC_W-1:0] rec, input int k, input bit asc);
    int e;
    if (k < N) begin
      e = asc ? k : (N - 1 - k);
      return 8'(rec >> (16 + 8 * e));
    end
    if (k == N) return rec[15:8];
    return rec[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [REC_W-1:0] d, input logic r);
    bus0.in_valid = v; bus0.in_data = d; bus0.out_ready = r;
    bus1.in_valid = v; bus1.in_data = d; bus1.out_ready = r;
  endtask

  task automatic set_ready(input logic r);
    bus0.out_ready = r;
    bus1.out_ready = r;
  endtask

  function automatic logic [REC_W-1:0] rand_rec();
    return {$urandom(), $urandom()};
  endfunction

  task automatic check_beat(input logic [REC_W-1:0] rec, input int k);
    check("valid0", 32'(bus0.out_valid), 1);
    check("valid1", 32'(bus1.out_valid), 1);
    check("busy0", 32'(bus0.in_ready), 0);
    check("data0", 32'(bus0.out_data), 32'(model_byte(rec, k, 1'b0)));
    check("data1", 32'(bus1.out_data), 32'(model_byte(rec, k, 1'b1)));
    check("idx0", 32'(bus0.out_idx), 32'(k));
    check("idx1", 32'(bus1.out_idx), 32'(k));
    check("last0", 32'(bus0.out_last), 32'(k == N + 1));
    check("last1", 32'(bus1.out_last), 32'(k == N + 1));
`ifdef STRUCT_UNPACK_PARITY_EN
    check("par0", 32'(bus0.out_parity), 32'(^model_byte(rec, k, 1'b0)));
    check("par1", 32'(bus1.out_parity), 32'(^model_byte(rec, k, 1'b1)));
`endif
  endtask

  // One full record: offer, capture, all beats with an optional stall, then idle check
  task automatic run_record(input logic [REC_W-1:0] rec, input int stall_at, input int stall_len,
                            input bit keep_valid, input logic [REC_W-1:0] next_rec);
    drive(1'b1, rec, 1'b1);
    check("idle_ready0", 32'(bus0.in_ready), 1);
    check("idle_ready1", 32'(bus1.in_ready), 1);
    @(posedge clk); #1;
    if (keep_valid) drive(1'b1, next_rec, 1'b1);
    else            drive(1'b0, rand_rec(), 1'b1);
    for (int k = 0; k < N + 2; k++) begin
      check_beat(rec, k);
      if (k == stall_at) begin
        set_ready(1'b0);
        for (int s = 0; s < stall_len; s++) begin
          @(posedge clk); #1;
          check_beat(rec, k);
        end
        set_ready(1'b1);
      end
      @(posedge clk); #1;
    end
    check("done_valid0", 32'(bus0.out_valid), 0);
    check("done_valid1", 32'(bus1.out_valid), 0);
    check("done_ready0", 32'(bus0.in_ready), 1);
  endtask

  logic [REC_W-1:0] r_a, r_b;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus0.in_ready), 1);
    check("rst_valid", 32'(bus0.out_valid), 0);
    check("rst_data", 32'(bus0.out_data), 0);
    check("rst_idx", 32'(bus0.out_idx), 0);
    check("rst_last", 32'(bus0.out_last), 0);
`ifdef STRUCT_UNPACK_PARITY_EN
    check("rst_par", 32'(bus0.out_parity), 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed record in both orders, then with a 3-cycle stall on beat 3
    r_a = {48'h4200_0012_3400, 16'hFFFC};
    check("model_b3", 32'(model_byte(r_a, 3, 1'b0)), 32'h12);
    run_record(r_a, -1, 0, 1'b0, '0);
    run_record(r_a, 3, 3, 1'b0, '0);

    // Back-to-back with in_valid held; in_data changes right after capture
    r_a = rand_rec();
    r_b = rand_rec();
    run_record(r_a, -1, 0, 1'b1, r_b);
    run_record(r_b, 2, 1, 1'b0, '0);

    // Reset during beat 4 discards the record
    r_a = rand_rec();
    drive(1'b1, r_a, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, '0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
    end
    check_beat(r_a, 4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid0", 32'(bus0.out_valid), 0);
    check("mid_rst_valid1", 32'(bus1.out_valid), 0);
    check("mid_rst_ready0", 32'(bus0.in_ready), 1);
    check("mid_rst_idx0", 32'(bus0.out_idx), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", 32'(bus0.out_valid), 0);
    run_record(rand_rec(), -1, 0, 1'b0, '0);

    // Random records with random stalls
    for (int i = 0; i < 6; i++) begin
      run_record(rand_rec(), int'($urandom_range(N + 2, 0)), int'($urandom_range(3, 1)), 1'b0, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
